// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and access checks
// for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  function automatic lsu_size_t size_of(
    input logic [2:0] f3
  );
    return lsu_size_t'(f3[1:0]);
  endfunction

  function automatic logic is_legal(
    input logic       ld,
    input logic       st,
    input logic [2:0] f3,
    input logic       rv64
  );
    logic ok;
    ok = 1'b0;
    case ({ld, st})
      2'b10: ok = (f3 != 3'b111) &&
                  (rv64 || (f3 != F3_LD &&
                            f3 != F3_LWU));
      2'b01: ok = !f3[2] &&
                  (rv64 || f3 != F3_SD);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(
    input lsu_size_t  sz,
    input logic [2:0] a
  );
    logic m;
    case (sz)
      SZ_H:    m = a[0];
      SZ_W:    m = |a[1:0];
      SZ_D:    m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response, flush/stall and
// data-memory bus of the load/store unit.
// slave = the LSU; master = pipeline plus memory side.
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              flush;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_mbe;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_resp;
  logic [XLEN-1:0]   mem_rdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic [4:0]        rsp_rd;
  logic              stall;
  logic              misalign;
  logic              illegal;

  modport slave (
    input  req_valid, req_load, req_store,
    input  req_funct3, req_addr, req_wdata,
    input  req_rd, flush, mem_resp, mem_rdata,
    output req_ready, mem_read, mem_write,
    output mem_addr, mem_mbe, mem_wdata,
    output rsp_valid, rsp_data, rsp_rd,
    output stall, misalign, illegal
  );

  modport master (
    output req_valid, req_load, req_store,
    output req_funct3, req_addr, req_wdata,
    output req_rd, flush, mem_resp, mem_rdata,
    input  req_ready, mem_read, mem_write,
    input  mem_addr, mem_mbe, mem_wdata,
    input  rsp_valid, rsp_data, rsp_rd,
    input  stall, misalign, illegal
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering. off/size/sgn in;
// mbe_o, shifted wdata_o and extended rdata_o out.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic [OW-1:0]   off,
  input  lsu_size_t       size,
  input  logic            sgn,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   mbe_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [7:0]      mask;
  logic [XLEN-1:0] sh;
  logic [63:0]     sh64;
  logic [63:0]     ext;

  always_comb begin
    case (size)
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      SZ_D:    mask = 8'hFF;
      default: mask = 8'h01;
    endcase
    mbe_o   = NB'(mask << off);
    wdata_o = wdata_i << {off, 3'b000};
    sh      = rdata_i >> {off, 3'b000};
    sh64    = 64'(sh);
    case (size)
      SZ_B: ext = {{56{sgn & sh64[7]}},
                   sh64[7:0]};
      SZ_H: ext = {{48{sgn & sh64[15]}},
                   sh64[15:0]};
      SZ_W: ext = {{32{sgn & sh64[31]}},
                   sh64[31:0]};
      default: ext = sh64;
    endcase
    rdata_o = XLEN'(ext);
  end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: memory-stage load/store unit, IDLE/BUSY
// handshake to data memory; clk, rst_n, bus (lsu_if).
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_t        state_q, state_d;
  logic              drop_q, drop_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     mbe_q, mbe_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  lsu_size_t         size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [OW-1:0]     off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic              misalign_q, misalign_d;
  logic              illegal_q, illegal_d;

  logic            idle, legal, mis;
  logic            accept, go;
  lsu_size_t       req_size, a_size;
  logic [OW-1:0]   a_off;
  logic [NB-1:0]   al_mbe;
  logic [XLEN-1:0] al_wdata, al_rdata;

  always_comb begin
    idle     = (state_q == IDLE);
    req_size = size_of(bus.req_funct3);
    legal    = is_legal(bus.req_load,
                        bus.req_store,
                        bus.req_funct3,
                        XLEN == 64);
    mis      = is_misaligned(req_size,
                             bus.req_addr[2:0]);
    accept   = bus.req_valid & idle & ~bus.flush &
               (bus.req_load | bus.req_store);
    go       = accept & legal & ~mis;
    // one aligner: request lanes in IDLE,
    // latched lanes for load extraction in BUSY
    a_off    = idle ? bus.req_addr[OW-1:0] : off_q;
    a_size   = idle ? req_size : size_q;
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .off     (a_off),
    .size    (a_size),
    .sgn     (sgn_q),
    .wdata_i (bus.req_wdata),
    .rdata_i (bus.mem_rdata),
    .mbe_o   (al_mbe),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    mbe_d       = mbe_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    misalign_d  = accept & legal & mis;
    illegal_d   = accept & ~legal;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d     = BUSY;
          mem_read_d  = bus.req_load;
          mem_write_d = bus.req_store;
          addr_d      = {bus.req_addr[ADDR_W-1:OW],
                         OW'(0)};
          mbe_d       = al_mbe;
          wdata_d     = al_wdata;
          size_d      = req_size;
          sgn_d       = ~bus.req_funct3[2];
          off_d       = bus.req_addr[OW-1:0];
          rd_d        = bus.req_rd;
          drop_d      = 1'b0;
        end
      end
      BUSY: begin
        // flushed access still runs to completion
        if (bus.flush) drop_d = 1'b1;
        if (bus.mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          drop_d      = 1'b0;
          if (!(drop_q | bus.flush)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_read_q ? al_rdata : '0;
            rsp_rd_d    = mem_read_q ? rd_q : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      mbe_q       <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_B;
      sgn_q       <= 1'b0;
      off_q       <= '0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      mbe_q       <= mbe_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.req_ready = idle;
  assign bus.stall     = ~idle |
                         (bus.req_valid & idle &
                          legal & ~mis);
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_mbe   = mbe_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.misalign  = misalign_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: vector table plus response scoreboard
// for lsu_stage at XLEN=32, and a few XLEN=64 ops.
module tb_lsu_stage;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lsu_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  lsu_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  lsu_stage #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32.slave)
  );

  lsu_stage #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          kind;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  int   pass_n = 0;
  int   total_n = 0;
  exp_t sb[$];
  vec_t tv[$];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h",
                  nm, got, exp);
  endtask

  function automatic vec_t mk(
    input logic ld, input logic st,
    input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input int waits, input int kind,
    input logic [3:0] mbe, input logic [31:0] mwd,
    input logic [31:0] data);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3;
    v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.waits = waits;
    v.kind = kind; v.mbe = mbe;
    v.mwd = mwd; v.data = data;
    return v;
  endfunction

  exp_t e;
  always @(negedge clk) begin
    if (rst_n && b32.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", b32.rsp_data, e.data);
        chk("rsp_rd", b32.rsp_rd, e.rd);
      end
    end
  end

  // called just after a falling edge
  task automatic run32(input vec_t v,
                       input logic [4:0] rd);
    logic [31:0] ea;
    ea = v.addr & 32'hFFFF_FFFC;
    b32.req_valid  = 1'b1;
    b32.req_load   = v.ld;
    b32.req_store  = v.st;
    b32.req_funct3 = v.f3;
    b32.req_addr   = v.addr;
    b32.req_wdata  = v.wdata;
    b32.req_rd     = rd;
    #1;
    chk("ready_acc", b32.req_ready, 1);
    if (v.kind != 1)
      chk("stall_acc", b32.stall, v.kind == 0);
    @(negedge clk);
    b32.req_valid = 1'b0;
    b32.req_load  = 1'b0;
    b32.req_store = 1'b0;
    if (v.kind == 0) begin
      chk("mem_read", b32.mem_read, v.ld);
      chk("mem_write", b32.mem_write, v.st);
      chk("mem_addr", b32.mem_addr, ea);
      chk("mem_mbe", b32.mem_mbe, v.mbe);
      if (v.st)
        chk("mem_wdata", b32.mem_wdata, v.mwd);
      sb.push_back('{v.st ? 32'h0 : v.data,
                     v.st ? 5'd0 : rd});
      for (int i = 0; i < v.waits; i++) begin
        @(negedge clk);
        chk("strobe_hold",
            {b32.mem_read, b32.mem_write},
            {v.ld, v.st});
        chk("stall_busy", b32.stall, 1);
      end
      b32.mem_resp  = 1'b1;
      b32.mem_rdata = v.rdata;
      @(negedge clk);
      b32.mem_resp  = 1'b0;
      b32.mem_rdata = $urandom;
      chk("rsp_latency", b32.rsp_valid, 1);
      chk("strobe_drop",
          {b32.mem_read, b32.mem_write}, 0);
    end else begin
      chk("misalign", b32.misalign, v.kind == 1);
      chk("illegal", b32.illegal, v.kind == 2);
      chk("no_strobe",
          {b32.mem_read, b32.mem_write}, 0);
      chk("ready_err", b32.req_ready, 1);
      @(negedge clk);
      chk("pulse_end",
          {b32.misalign, b32.illegal}, 0);
    end
  endtask

  task automatic run64(
    input logic ld, input logic st,
    input logic [2:0] f3, input logic [31:0] addr,
    input logic [63:0] wd, input logic [63:0] rdat,
    input logic [7:0] mbe, input logic [63:0] mwd,
    input logic [63:0] data);
    b64.req_valid  = 1'b1;
    b64.req_load   = ld;
    b64.req_store  = st;
    b64.req_funct3 = f3;
    b64.req_addr   = addr;
    b64.req_wdata  = wd;
    b64.req_rd     = 5'd3;
    @(negedge clk);
    b64.req_valid = 1'b0;
    chk("m64_addr", b64.mem_addr,
        addr & 32'hFFFF_FFF8);
    chk("m64_mbe", b64.mem_mbe, mbe);
    if (st) chk("m64_wdata", b64.mem_wdata, mwd);
    b64.mem_resp  = 1'b1;
    b64.mem_rdata = rdat;
    @(negedge clk);
    b64.mem_resp = 1'b0;
    chk("r64_valid", b64.rsp_valid, 1);
    chk("r64_data", b64.rsp_data, data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b32.req_valid = 0; b32.req_load = 0;
    b32.req_store = 0; b32.req_funct3 = 0;
    b32.req_addr = 0; b32.req_wdata = 0;
    b32.req_rd = 0; b32.flush = 0;
    b32.mem_resp = 0; b32.mem_rdata = 0;
    b64.req_valid = 0; b64.req_load = 0;
    b64.req_store = 0; b64.req_funct3 = 0;
    b64.req_addr = 0; b64.req_wdata = 0;
    b64.req_rd = 0; b64.flush = 0;
    b64.mem_resp = 0; b64.mem_rdata = 0;

    tv.push_back(mk(1,0,F3_LB, 32'h1003,0,32'h80FF_0000,
                    0,0,4'h8,0,32'hFFFF_FF80));
    tv.push_back(mk(1,0,F3_LBU,32'h1002,0,32'h80FF_0000,
                    1,0,4'h4,0,32'h0000_00FF));
    tv.push_back(mk(1,0,F3_LH, 32'h2002,0,32'h80FF_0000,
                    0,0,4'hC,0,32'hFFFF_80FF));
    tv.push_back(mk(1,0,F3_LHU,32'h2000,0,32'h1234_8001,
                    2,0,4'h3,0,32'h0000_8001));
    tv.push_back(mk(1,0,F3_LW, 32'h3000,0,32'hDEAD_BEEF,
                    1,0,4'hF,0,32'hDEAD_BEEF));
    tv.push_back(mk(0,1,F3_SH, 32'h2002,32'h0000_BEEF,0,
                    3,0,4'hC,32'hBEEF_0000,0));
    tv.push_back(mk(0,1,F3_SB, 32'h1001,32'h1234_56A5,0,
                    0,0,4'h2,32'h3456_A500,0));
    tv.push_back(mk(0,1,F3_SW, 32'h0040,32'hCAFE_F00D,0,
                    2,0,4'hF,32'hCAFE_F00D,0));
    tv.push_back(mk(1,0,F3_LW, 32'h3001,0,0,0,1,0,0,0));
    tv.push_back(mk(1,0,F3_LH, 32'h3003,0,0,0,1,0,0,0));
    tv.push_back(mk(0,1,F3_SW, 32'h2006,0,0,0,1,0,0,0));
    tv.push_back(mk(1,0,3'b011,32'h3000,0,0,0,2,0,0,0));
    tv.push_back(mk(1,0,3'b011,32'h3001,0,0,0,2,0,0,0));
    tv.push_back(mk(0,1,3'b011,32'h3000,0,0,0,2,0,0,0));
    tv.push_back(mk(0,1,3'b100,32'h3000,0,0,0,2,0,0,0));
    tv.push_back(mk(1,0,3'b111,32'h3000,0,0,0,2,0,0,0));
    tv.push_back(mk(1,0,3'b110,32'h3000,0,0,0,2,0,0,0));
    tv.push_back(mk(1,1,F3_LW, 32'h3000,0,0,0,2,0,0,0));
    tv.push_back(mk(1,0,F3_LB, 32'h1000,0,32'h0000_007F,
                    0,0,4'h1,0,32'h0000_007F));

    repeat (2) @(negedge clk);
    chk("rst_ready", b32.req_ready, 1);
    chk("rst_strobes",
        {b32.mem_read, b32.mem_write}, 0);
    chk("rst_pulses", {b32.rsp_valid,
        b32.misalign, b32.illegal, b32.stall}, 0);
    chk("rst_mem_addr", b32.mem_addr, 0);
    chk("rst_mbe_wdata",
        {b32.mem_mbe, b32.mem_wdata}, 0);
    chk("rst_rsp", {b32.rsp_data, b32.rsp_rd}, 0);
    chk("rst_ready64", b64.req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tv[i]) run32(tv[i], 5'(i + 1));

    // flush while BUSY: access completes silently
    b32.req_valid = 1; b32.req_load = 1;
    b32.req_funct3 = F3_LW; b32.req_addr = 32'h3000;
    b32.req_rd = 5'd7;
    @(negedge clk);
    b32.req_valid = 0; b32.req_load = 0;
    chk("fl_busy_read", b32.mem_read, 1);
    b32.flush = 1;
    @(negedge clk);
    b32.flush = 0;
    chk("fl_read_held", b32.mem_read, 1);
    @(negedge clk);
    b32.mem_resp = 1; b32.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    b32.mem_resp = 0;
    chk("fl_no_rsp", b32.rsp_valid, 0);
    chk("fl_ready", b32.req_ready, 1);
    chk("fl_strobe_drop", b32.mem_read, 0);
    run32(mk(1,0,F3_LW,32'h3004,0,32'h5555_AAAA,
             0,0,4'hF,0,32'h5555_AAAA), 5'd9);

    // flush on the response edge
    b32.req_valid = 1; b32.req_load = 1;
    b32.req_funct3 = F3_LH; b32.req_addr = 32'h2000;
    @(negedge clk);
    b32.req_valid = 0; b32.req_load = 0;
    b32.mem_resp = 1; b32.flush = 1;
    @(negedge clk);
    b32.mem_resp = 0; b32.flush = 0;
    chk("flr_no_rsp", b32.rsp_valid, 0);
    chk("flr_idle", b32.req_ready, 1);
    run32(mk(1,0,F3_LHU,32'h2002,0,32'hF00D_0000,
             0,0,4'hC,0,32'h0000_F00D), 5'd10);

    // flush in IDLE blocks acceptance
    b32.req_valid = 1; b32.req_load = 1;
    b32.req_funct3 = F3_LW; b32.req_addr = 32'h3000;
    b32.flush = 1;
    @(negedge clk);
    b32.req_valid = 0; b32.req_load = 0;
    b32.flush = 0;
    chk("fli_no_read", b32.mem_read, 0);
    chk("fli_idle", b32.req_ready, 1);
    @(negedge clk);

    // reset while BUSY
    b32.req_valid = 1; b32.req_store = 1;
    b32.req_funct3 = F3_SW; b32.req_addr = 32'h40;
    b32.req_wdata = 32'h0BAD_CAFE;
    @(negedge clk);
    b32.req_valid = 0; b32.req_store = 0;
    chk("rb_write", b32.mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_async_drop", b32.mem_write, 0);
    chk("rb_stall", b32.stall, 0);
    chk("rb_ready", b32.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    b32.mem_resp = 1;
    @(negedge clk);
    b32.mem_resp = 0;
    chk("rb_no_rsp", b32.rsp_valid, 0);
    chk("rb_no_strobe",
        {b32.mem_read, b32.mem_write}, 0);
    @(negedge clk);

    run64(1,0,F3_LWU,32'h4004,0,
          64'h8000_0001_0000_0000,8'hF0,0,
          64'h0000_0000_8000_0001);
    run64(1,0,F3_LW,32'h4004,0,
          64'h8000_0001_0000_0000,8'hF0,0,
          64'hFFFF_FFFF_8000_0001);
    run64(1,0,F3_LD,32'h4008,0,
          64'h8123_4567_89AB_CDEF,8'hFF,0,
          64'h8123_4567_89AB_CDEF);
    run64(1,0,F3_LH,32'h4006,0,
          64'h8001_0000_0000_0000,8'hC0,0,
          64'hFFFF_FFFF_FFFF_8001);
    run64(0,1,F3_SD,32'h4010,
          64'h1122_3344_5566_7788,0,8'hFF,
          64'h1122_3344_5566_7788,0);
    run64(0,1,F3_SW,32'h4014,
          64'h0000_0000_CAFE_F00D,0,8'hF0,
          64'hCAFE_F00D_0000_0000,0);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Parametrised load/store unit for the pipelined RV32I/RV64I core's memory stage. It replaces the fixed single-cycle data-memory hookup with a request/response handshake and a stall output. It generates byte enables and lane-shifted store data, and sign/zero-extends load data. It flags misaligned and illegal accesses and supports flush of an in-flight access.

## Interface
- XLEN, 32: data width, 32 or 64; 64 enables ld/lwu/sd.
- ADDR_W, 32: address width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory op presented by EX/MEM register.
- req_ready  out  XLEN-independent 1  unit can accept (state IDLE).
- req_load / req_store  in  1 each  op kind; both 0 = no memory op, both 1 = illegal.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  XLEN  rs2 data, unshifted.
- req_rd  in  5  load destination.
- flush  in  1  discard current/in-flight op.
- mem_read / mem_write  out  1  data-memory strobes.
- mem_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits cleared.
- mem_mbe  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_resp  in  1  memory completion.
- mem_rdata  in  XLEN  raw read word.
- rsp_valid  out  1  one-cycle pulse, load result or store completion.
- rsp_data  out  XLEN  extended load data (0 for stores).
- rsp_rd  out  5  destination (0 for stores).
- stall  out  1  hold upstream pipeline.
- misalign  out  1  one-cycle pulse, address not size-aligned.
- illegal  out  1  one-cycle pulse, bad funct3/kind combination.

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- Accept = req_valid & req_ready & ~flush & (req_load | req_store).
- Illegal: funct3 not a valid load/store for the kind, 64-bit ops with XLEN=32, or load & store both set. On accept, illegal pulses next cycle, no memory access, stays IDLE.
- Misaligned: half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0. Same handling as illegal. Illegal has priority over misalign.
- Legal accept → BUSY. Latch addr, size, signedness, rd, and shifted wdata/mbe. Drive mem_read or mem_write from the next cycle, held constant until mem_resp.
- mbe = size mask (1/3/F/FF) << byte offset. wdata = req_wdata << 8·offset.
- Load result: shift mem_rdata right by 8·offset, then sign- or zero-extend from 8/16/32 bits. ld passes through.
- BUSY & mem_resp → IDLE. Strobes drop the same edge. rsp_valid pulses for one cycle unless the drop flag is set.
- flush in BUSY: set drop flag. The access still completes (no abort). Response is suppressed and the flag clears on mem_resp.
- flush in IDLE blocks acceptance that cycle.
- flush coincident with mem_resp suppresses the response.
- stall = (state==BUSY) | (req_valid & req_ready & legal op). Stall covers the accept cycle so the pipeline holds.

## Timing
- Reset values: state IDLE, mem_read/mem_write/rsp_valid/misalign/illegal/stall 0, mem_addr/mem_mbe/mem_wdata/rsp_data/rsp_rd 0, drop flag 0. req_ready 1.
- Accept at edge T. Strobes high in cycle T+1. mem_resp sampled at earliest edge T+2. rsp_valid high in cycle T+2 (minimum load-to-result latency 2).
- Each additional wait cycle adds one cycle. There is no timeout.
- rsp_* registered. req_ready and stall combinational from state and inputs.
- Back-to-back: a new op can be accepted in the cycle rsp_valid is high.
- rst_n mid-BUSY: immediate return to IDLE, strobes drop asynchronously, no response.

## Structure
- lsu_pkg: lsu_state_t {IDLE, BUSY}, lsu_size_t {B, H, W, D}, load/store funct3 constants, size_of()/is_legal() functions.
- Sub-module lsu_align (combinational): offset, size, sign → mbe, shifted wdata, extended rdata. Instanced once, parametrised by XLEN.

## Test plan
- XLEN=32, lb at 0x1003, mem_rdata 0x80FF_0000, resp after 0 waits → rsp_data 0xFFFF_FF80, rsp_valid at T+2, mem_addr 0x1000.
- sh at 0x2002, wdata 0x0000_BEEF → mem_mbe 0xC, mem_wdata 0xBEEF_0000, mem_write held over 3 wait cycles, stall high throughout.
- lw at 0x3001 → misalign pulse at T+1, no mem_read, req_ready stays 1. funct3 011 with XLEN=32 → illegal pulse.
- Load accepted, flush in BUSY, resp 2 cycles later → no rsp_valid; next op accepted the following cycle.
- XLEN=64, lwu at 0x4004, mem_rdata 0x8000_0001_0000_0000 → mem_mbe 0xF0, rsp_data 0x0000_0000_8000_0001.
- rst_n low during BUSY → strobes 0 immediately, state IDLE, no response after release.
